// File: rtl/mac_selftest_pkg.sv
// Shared definitions for the MAC self-test block: FSM encoding, LFSR
// polynomial and the fixed MAC pipeline depth.
package mac_selftest_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_RUN   = 3'd1;
  localparam state_t ST_DRAIN = 3'd2;
  localparam state_t ST_CHECK = 3'd3;
  localparam state_t ST_DONE  = 3'd4;

  // Galois form of x^16 + x^14 + x^13 + x^11 + 1
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  localparam int PIPE = 3;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/mac_pipe.sv
// Three-stage unsigned multiply-accumulate (input reg, product reg,
// accumulate reg) laid out so the multiplier maps onto a DSP block.
module mac_pipe #(
  parameter int WIDTH     = 16,
  parameter int ACC_WIDTH = 2*WIDTH+8
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   clr,
  input  logic                   in_valid,
  input  logic [WIDTH-1:0]       a,
  input  logic [WIDTH-1:0]       b,
  input  logic                   fault,
  output logic [2*WIDTH-1:0]     prod,
  output logic                   prod_valid,
  output logic [ACC_WIDTH-1:0]   acc
);

  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             in_valid_r;

  // The fault flips product bit 0 only as it is captured in the product register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      a_r        <= '0;
      b_r        <= '0;
      in_valid_r <= 1'b0;
      prod       <= '0;
      prod_valid <= 1'b0;
      acc        <= '0;
    end else if (clr) begin
      a_r        <= '0;
      b_r        <= '0;
      in_valid_r <= 1'b0;
      prod       <= '0;
      prod_valid <= 1'b0;
      acc        <= '0;
    end else begin
      a_r        <= a;
      b_r        <= b;
      in_valid_r <= in_valid;
      prod       <= ((2*WIDTH)'(a_r) * (2*WIDTH)'(b_r)) ^ (2*WIDTH)'(fault);
      prod_valid <= in_valid_r;
      if (prod_valid)
        acc <= acc + ACC_WIDTH'(prod);
    end
  end

endmodule

// File: rtl/mac_selftest.sv
// Built-in self test for the MAC pipeline: streams generated operand pairs
// through mac_pipe and checks every product against a delayed reference.
module mac_selftest
  import mac_selftest_pkg::*;
#(
  parameter int          WIDTH     = 16,
  parameter int          ACC_WIDTH = 2*WIDTH+8,
  parameter int          NUM_VEC   = 256,
  parameter int          MODE      = 0,
  parameter logic [15:0] SEED      = 16'hACE1
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 start,
  input  logic                 inj_fault,
  output logic                 busy,
  output logic                 done,
  output logic                 correct,
  output logic [7:0]           err_count,
  output logic [ACC_WIDTH-1:0] acc_out
);

  state_t                 state;
  logic [15:0]            vec_idx;
  logic [15:0]            idx_next;
  logic [15:0]            lfsr;
  logic [1:0]             drain_cnt;
  logic                   launch;
  logic                   issue;
  logic                   last_vec;
  logic                   mismatch;
  logic [WIDTH-1:0]       op_a;
  logic [WIDTH-1:0]       op_b;
  logic [2*WIDTH-1:0]     ref_prod;
  logic [2*WIDTH-1:0]     ref_d1;
  logic [2*WIDTH-1:0]     ref_d2;
  logic [2*WIDTH-1:0]     pipe_prod;
  logic                   pipe_valid;
  logic [ACC_WIDTH-1:0]   ref_acc;
  logic [ACC_WIDTH-1:0]   pipe_acc;

  assign launch   = start && ((state == ST_IDLE) || (state == ST_DONE));
  assign issue    = (state == ST_RUN);
  assign last_vec = (vec_idx == 16'(NUM_VEC - 1));
  assign idx_next = vec_idx + 16'd1;

  always_comb begin
    op_a = '0;
    op_b = '0;
    if (MODE == 0) begin
      op_a = lfsr[WIDTH-1:0];
      op_b = lfsr[15:16-WIDTH];
    end else begin
      op_a = vec_idx[WIDTH-1:0];
      op_b = idx_next[WIDTH-1:0];
    end
  end

  assign ref_prod = (2*WIDTH)'(op_a) * (2*WIDTH)'(op_b);

  mac_pipe #(
    .WIDTH     (WIDTH),
    .ACC_WIDTH (ACC_WIDTH)
  ) u_mac (
    .CLK        (CLK),
    .RST        (RST),
    .clr        (launch),
    .in_valid   (issue),
    .a          (op_a),
    .b          (op_b),
    .fault      (inj_fault),
    .prod       (pipe_prod),
    .prod_valid (pipe_valid),
    .acc        (pipe_acc)
  );

  // Sequencer: the launch edge reloads the generator so every run is identical
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= ST_IDLE;
      vec_idx   <= '0;
      drain_cnt <= '0;
      lfsr      <= SEED;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (launch) begin
            state     <= ST_RUN;
            vec_idx   <= '0;
            drain_cnt <= '0;
            lfsr      <= SEED;
          end
        end
        ST_RUN: begin
          vec_idx <= idx_next;
          lfsr    <= lfsr_step(lfsr);
          if (last_vec) begin
            state     <= ST_DRAIN;
            drain_cnt <= '0;
          end
        end
        ST_DRAIN: begin
          drain_cnt <= drain_cnt + 2'd1;
          if (drain_cnt == 2'(PIPE - 1))
            state <= ST_CHECK;
        end
        ST_CHECK: state <= ST_DONE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  // Reference products are delayed PIPE-1 cycles so they meet pipe_prod
  assign mismatch = pipe_valid && (pipe_prod != ref_d2);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ref_d1    <= '0;
      ref_d2    <= '0;
      ref_acc   <= '0;
      err_count <= '0;
      correct   <= 1'b0;
    end else if (launch) begin
      ref_d1    <= '0;
      ref_d2    <= '0;
      ref_acc   <= '0;
      err_count <= '0;
      correct   <= 1'b0;
    end else begin
      ref_d1 <= ref_prod;
      ref_d2 <= ref_d1;
      if (pipe_valid)
        ref_acc <= ref_acc + ACC_WIDTH'(ref_d2);
      if (mismatch && (err_count != 8'hFF))
        err_count <= err_count + 8'd1;
      if (state == ST_CHECK)
        correct <= (err_count == 8'd0) && (pipe_acc == ref_acc);
    end
  end

  assign busy    = (state == ST_RUN) || (state == ST_DRAIN) || (state == ST_CHECK);
  assign done    = (state == ST_DONE);
  assign acc_out = pipe_acc;

endmodule

// File: tb/tb_mac_selftest.sv
// Directed bench for mac_selftest: three configurations driven from one
// linear sequence of steps, checked with immediate assertions.
module tb_mac_selftest;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  logic start_a = 1'b0, inj_a = 1'b0;
  logic start_b = 1'b0, inj_b = 1'b0;
  logic start_c = 1'b0, inj_c = 1'b0;

  logic        busy_a, done_a, correct_a;
  logic [7:0]  err_a;
  logic [23:0] acc_a;
  logic        busy_b, done_b, correct_b;
  logic [7:0]  err_b;
  logic [15:0] acc_b;
  logic        busy_c, done_c, correct_c;
  logic [7:0]  err_c;
  logic [31:0] acc_c;

  int checks   = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  mac_selftest #(.WIDTH(8), .NUM_VEC(4), .MODE(1)) u_a (
    .CLK(CLK), .RST(RST), .start(start_a), .inj_fault(inj_a),
    .busy(busy_a), .done(done_a), .correct(correct_a),
    .err_count(err_a), .acc_out(acc_a)
  );

  mac_selftest #(.WIDTH(4), .NUM_VEC(300), .MODE(1)) u_b (
    .CLK(CLK), .RST(RST), .start(start_b), .inj_fault(inj_b),
    .busy(busy_b), .done(done_b), .correct(correct_b),
    .err_count(err_b), .acc_out(acc_b)
  );

  mac_selftest #(.WIDTH(16), .ACC_WIDTH(32), .NUM_VEC(256), .MODE(0)) u_c (
    .CLK(CLK), .RST(RST), .start(start_c), .inj_fault(inj_c),
    .busy(busy_c), .done(done_c), .correct(correct_c),
    .err_count(err_c), .acc_out(acc_c)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic logic busy_of(input int which);
    case (which)
      0:       return busy_a;
      1:       return busy_b;
      default: return busy_c;
    endcase
  endfunction

  task automatic set_start(input int which, input logic v);
    case (which)
      0:       start_a = v;
      1:       start_b = v;
      default: start_c = v;
    endcase
  endtask

  // Pulse start, optionally pulse it again after extra_at busy cycles,
  // then count busy cycles until the run finishes or the budget expires.
  task automatic applyStimulus(input int which, input int extra_at, output int cycles);
    set_start(which, 1'b1);
    @(negedge CLK);
    set_start(which, 1'b0);
    cycles = 0;
    while (busy_of(which) && cycles < 2000) begin
      set_start(which, cycles == extra_at);
      cycles++;
      @(negedge CLK);
    end
    set_start(which, 1'b0);
  endtask

  logic [15:0] s;
  logic [31:0] model_sum;
  int          cyc;

  initial begin
    // Independent model of the LFSR-mode sum for configuration C
    s = 16'hACE1;
    model_sum = '0;
    for (int i = 0; i < 256; i++) begin
      model_sum = model_sum + 32'(s) * 32'(s);
      s = s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
    end

    repeat (3) @(negedge CLK);
    checkOutput("rst_busy",    64'(busy_a),    64'd0);
    checkOutput("rst_done",    64'(done_a),    64'd0);
    checkOutput("rst_correct", 64'(correct_a), 64'd0);
    checkOutput("rst_err",     64'(err_a),     64'd0);
    checkOutput("rst_acc",     64'(acc_a),     64'd0);
    RST = 1'b0;
    repeat (2) @(negedge CLK);

    // Counter mode, 4 vectors: 0*1+1*2+2*3+3*4 = 20
    applyStimulus(0, -1, cyc);
    checkOutput("a_busy_cycles", 64'(cyc),       64'd8);
    checkOutput("a_done",        64'(done_a),    64'd1);
    checkOutput("a_correct",     64'(correct_a), 64'd1);
    checkOutput("a_err",         64'(err_a),     64'd0);
    checkOutput("a_acc",         64'(acc_a),     64'd20);
    repeat (3) @(negedge CLK);
    checkOutput("a_hold_acc",    64'(acc_a),     64'd20);
    checkOutput("a_hold_done",   64'(done_a),    64'd1);

    // Fault on every product: bit 0 flips 0,2,6,12 -> 1,3,7,13 = 24
    inj_a = 1'b1;
    applyStimulus(0, -1, cyc);
    inj_a = 1'b0;
    checkOutput("f_err",     64'(err_a),     64'd4);
    checkOutput("f_correct", 64'(correct_a), 64'd0);
    checkOutput("f_done",    64'(done_a),    64'd1);
    checkOutput("f_acc",     64'(acc_a),     64'd24);

    // Asynchronous reset in RUN cycle 2
    start_a = 1'b1;
    @(negedge CLK);
    start_a = 1'b0;
    repeat (2) @(negedge CLK);
    checkOutput("r_busy_before", 64'(busy_a), 64'd1);
    RST = 1'b1;
    #1;
    checkOutput("r_busy",    64'(busy_a),    64'd0);
    checkOutput("r_done",    64'(done_a),    64'd0);
    checkOutput("r_correct", 64'(correct_a), 64'd0);
    checkOutput("r_err",     64'(err_a),     64'd0);
    checkOutput("r_acc",     64'(acc_a),     64'd0);
    @(negedge CLK);
    RST = 1'b0;
    repeat (3) @(negedge CLK);
    checkOutput("r_idle_busy", 64'(busy_a), 64'd0);
    checkOutput("r_idle_done", 64'(done_a), 64'd0);
    applyStimulus(0, -1, cyc);
    checkOutput("r_busy_cycles", 64'(cyc),       64'd8);
    checkOutput("r_acc_rerun",   64'(acc_a),     64'd20);
    checkOutput("r_correct2",    64'(correct_a), 64'd1);

    // Start while busy is ignored: still 4+3+1 busy cycles, same sum
    applyStimulus(0, 2, cyc);
    checkOutput("i_busy_cycles", 64'(cyc),   64'd8);
    checkOutput("i_acc",         64'(acc_a), 64'd20);
    checkOutput("i_done",        64'(done_a), 64'd1);

    // 300 faulted vectors saturate the error counter
    inj_b = 1'b1;
    applyStimulus(1, -1, cyc);
    inj_b = 1'b0;
    checkOutput("s_busy_cycles", 64'(cyc),       64'd304);
    checkOutput("s_err",         64'(err_b),     64'd255);
    checkOutput("s_correct",     64'(correct_b), 64'd0);
    checkOutput("s_done",        64'(done_b),    64'd1);

    // LFSR mode with a stray start mid-run, then a rerun from DONE
    applyStimulus(2, 5, cyc);
    checkOutput("l_busy_cycles", 64'(cyc),       64'd260);
    checkOutput("l_acc",         64'(acc_c),     64'(model_sum));
    checkOutput("l_correct",     64'(correct_c), 64'd1);
    checkOutput("l_err",         64'(err_c),     64'd0);
    applyStimulus(2, -1, cyc);
    checkOutput("l_acc_rerun",   64'(acc_c),     64'(model_sum));
    checkOutput("l_correct2",    64'(correct_c), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
